// File: rtl/fpu_slot_responder.sv
// -----------------------------------------------------------------------------
// fpu_slot_responder
//
// FPU-side responder for one shared FPU slot on the cluster FPU interconnect.
// Accepts req/gnt operations and dispatches each to either a fixed-latency
// pipelined datapath or an iterative div/sqrt unit. Every accepted request
// returns exactly one in-order rvalid_o pulse carrying result, IEEE flags and
// the request ID. At most one response leaves per cycle, so the pending count
// kept by the interconnect-side clock-gating logic stays exact.
//
// Build option:
//   FPU_SLOT_DIVSQRT_EN  defined   -> iterative div/sqrt path present
//                                     (FSM with IDLE / DIV_BUSY).
//                        undefined -> no iterative path; div-class ops are
//                                     accepted like pipe ops and answered
//                                     LATENCY cycles later with rdata_o=0 and
//                                     rflags_o=NV.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_i, op_i, operand_a_i,  request channel; payload held until granted
//   operand_b_i, id_i
//   gnt_o                      combinational grant
//   rvalid_o, rdata_o,         response channel; one-cycle pulse, no
//   rflags_o, rid_o            backpressure; data holds while rvalid_o=0
//   ex_valid_o, ex_op_o,       issue to the pipelined datapath
//   ex_a_o, ex_b_o
//   ex_res_i, ex_flags_i       pipelined result, valid LATENCY-1 cycles
//                              after issue
//   div_start_o                start pulse to the iterative unit
//   div_done_i, div_res_i,     iterative completion strobe and result
//   div_flags_i
//   busy_o                     slot has work outstanding
// -----------------------------------------------------------------------------
module fpu_slot_responder #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned OP_WIDTH   = 6,
   parameter int unsigned ID_WIDTH   = 6,
   parameter int unsigned LATENCY    = 3,
   parameter int unsigned OP_DIV     = 4,
   parameter int unsigned OP_SQRT    = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   // request channel
   input  logic                  req_i,
   input  logic [OP_WIDTH-1:0]   op_i,
   input  logic [DATA_WIDTH-1:0] operand_a_i,
   input  logic [DATA_WIDTH-1:0] operand_b_i,
   input  logic [ID_WIDTH-1:0]   id_i,
   output logic                  gnt_o,
   // response channel
   output logic                  rvalid_o,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic [4:0]            rflags_o,
   output logic [ID_WIDTH-1:0]   rid_o,
   // pipelined datapath
   output logic                  ex_valid_o,
   output logic [OP_WIDTH-1:0]   ex_op_o,
   output logic [DATA_WIDTH-1:0] ex_a_o,
   output logic [DATA_WIDTH-1:0] ex_b_o,
   input  logic [DATA_WIDTH-1:0] ex_res_i,
   input  logic [4:0]            ex_flags_i,
   // iterative div/sqrt unit
   output logic                  div_start_o,
   input  logic                  div_done_i,
   input  logic [DATA_WIDTH-1:0] div_res_i,
   input  logic [4:0]            div_flags_i,
   // activity
   output logic                  busy_o
);

   // {NV,DZ,OF,UF,NX}: invalid operation only
   localparam logic [4:0]  FLAGS_NV = 5'b10000;
   localparam int unsigned DLY_ID_W = LATENCY * ID_WIDTH;

   // ---------------------------------------------------------------------------
   // Request classification and grant
   // ---------------------------------------------------------------------------
   logic is_div;
   logic grant;
   logic issue_valid;   // request enters the delay line this cycle
   logic issue_err;     // entry must be answered with an NV error
   logic inflight_any;  // any registered delay-line stage valid
   logic fsm_busy;

   assign is_div = (op_i == OP_WIDTH'(OP_DIV)) || (op_i == OP_WIDTH'(OP_SQRT));

   assign gnt_o      = grant;
   assign ex_valid_o = req_i & grant & ~is_div;
   assign ex_op_o    = op_i;
   assign ex_a_o     = operand_a_i;
   assign ex_b_o     = operand_b_i;

   // ---------------------------------------------------------------------------
   // Iterative path (optional)
   // ---------------------------------------------------------------------------
`ifdef FPU_SLOT_DIVSQRT_EN
   localparam logic [0:0] IDLE     = 1'b0;
   localparam logic [0:0] DIV_BUSY = 1'b1;

   logic [0:0]          state_q, state_d;
   logic [ID_WIDTH-1:0] div_id_q, div_id_d;
   logic                div_accept;
   logic                div_capture;

   // A div may only start once the delay line has drained; this is what keeps
   // responses in issue order without a reorder buffer.
   assign grant       = req_i & (state_q == IDLE) & (~is_div | ~inflight_any);
   assign div_accept  = req_i & grant & is_div;
   assign div_capture = (state_q == DIV_BUSY) & div_done_i;
   assign div_start_o = div_accept;
   assign issue_valid = req_i & grant & ~is_div;
   assign issue_err   = 1'b0;
   assign fsm_busy    = (state_q != IDLE);

   always_comb begin
      state_d  = state_q;
      div_id_d = div_id_q;
      case (state_q)
         IDLE: begin
            if (div_accept) begin
               state_d  = DIV_BUSY;
               div_id_d = id_i;
            end
         end
         DIV_BUSY: begin
            if (div_done_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         div_id_q <= '0;
      end else begin
         state_q  <= state_d;
         div_id_q <= div_id_d;
      end
   end
`else
   // Without the iterative unit the slot is always idle from the FSM's point
   // of view; div-class ops ride the delay line tagged as errors.
   logic unused_div;

   assign grant       = req_i;
   assign div_start_o = 1'b0;
   assign issue_valid = req_i & grant;
   assign issue_err   = is_div;
   assign fsm_busy    = 1'b0;
   assign unused_div  = ^{div_done_i, div_res_i, div_flags_i};
`endif

   // ---------------------------------------------------------------------------
   // Inflight delay line
   // Stage 0 is the issuing request itself (combinational); stages
   // 1..LATENCY-1 are registered. Stage LATENCY-1 lines up with ex_res_i being
   // valid, so it is captured straight into the response registers and
   // rvalid_o follows LATENCY cycles after the grant.
   // ---------------------------------------------------------------------------
   logic [LATENCY-1:0]  stg_valid;
   logic [LATENCY-1:0]  stg_err;
   logic [DLY_ID_W-1:0] stg_id;
   logic                head_valid;
   logic                head_err;
   logic [ID_WIDTH-1:0] head_id;

   assign stg_valid[0]          = issue_valid;
   assign stg_err[0]            = issue_err;
   assign stg_id[ID_WIDTH-1:0]  = id_i;

   generate
      if (LATENCY > 1) begin : g_dly
         logic [LATENCY-1:1]              valid_q;
         logic [LATENCY-1:1]              err_q;
         logic [(LATENCY-1)*ID_WIDTH-1:0] id_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               valid_q <= '0;
               err_q   <= '0;
               id_q    <= '0;
            end else begin
               valid_q <= stg_valid[LATENCY-2:0];
               err_q   <= stg_err[LATENCY-2:0];
               id_q    <= stg_id[(LATENCY-1)*ID_WIDTH-1:0];
            end
         end

         assign stg_valid[LATENCY-1:1]           = valid_q;
         assign stg_err[LATENCY-1:1]             = err_q;
         assign stg_id[DLY_ID_W-1:ID_WIDTH]      = id_q;
         assign inflight_any                     = |valid_q;
      end else begin : g_no_dly
         assign inflight_any = 1'b0;
      end
   endgenerate

   assign head_valid = stg_valid[LATENCY-1];
   assign head_err   = stg_err[LATENCY-1];
   assign head_id    = stg_id[DLY_ID_W-1 -: ID_WIDTH];

   // ---------------------------------------------------------------------------
   // Response registers
   // ---------------------------------------------------------------------------
   logic                  rvalid_q, rvalid_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [4:0]            rflags_q, rflags_d;
   logic [ID_WIDTH-1:0]   rid_q, rid_d;

   always_comb begin
      rvalid_d = 1'b0;
      rdata_d  = rdata_q;
      rflags_d = rflags_q;
      rid_d    = rid_q;
      if (head_valid) begin
         rvalid_d = 1'b1;
         rid_d    = head_id;
         rdata_d  = head_err ? '0 : ex_res_i;
         rflags_d = head_err ? FLAGS_NV : ex_flags_i;
      end
`ifdef FPU_SLOT_DIVSQRT_EN
      // Never coincides with head_valid: the line is empty while DIV_BUSY.
      else if (div_capture) begin
         rvalid_d = 1'b1;
         rid_d    = div_id_q;
         rdata_d  = div_res_i;
         rflags_d = div_flags_i;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         rflags_q <= '0;
         rid_q    <= '0;
      end else begin
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         rflags_q <= rflags_d;
         rid_q    <= rid_d;
      end
   end

   assign rvalid_o = rvalid_q;
   assign rdata_o  = rdata_q;
   assign rflags_o = rflags_q;
   assign rid_o    = rid_q;
   assign busy_o   = fsm_busy | inflight_any | rvalid_q;

   // ---------------------------------------------------------------------------
   // Invariants
   // ---------------------------------------------------------------------------
`ifdef FPU_SLOT_DIVSQRT_EN
   a_one_response: assert property (@(posedge clk) disable iff (!rst_n)
      !(head_valid && div_capture));
   a_div_after_drain: assert property (@(posedge clk) disable iff (!rst_n)
      div_start_o |-> !inflight_any);
`endif
   a_rvalid_busy: assert property (@(posedge clk) disable iff (!rst_n)
      rvalid_o |-> busy_o);

endmodule

// File: tb/tb_fpu_slot_responder.sv
// -----------------------------------------------------------------------------
// tb_fpu_slot_responder
//
// Self-checking bench for fpu_slot_responder (LATENCY=3). Directed scenarios
// follow the slot's documented timing; a randomized run compares the DUT
// against a transaction-level model (queue of accepted ops with due cycles).
// Follows FPU_SLOT_DIVSQRT_EN to pick the expected div/sqrt behaviour.
// -----------------------------------------------------------------------------
module tb_fpu_slot_responder;

   localparam int DW = 32;
   localparam int OW = 6;
   localparam int IW = 6;
   localparam int L  = 3;
   localparam int NC = 400;
   localparam logic [OW-1:0] OPD = 6'd4;
   localparam logic [OW-1:0] OPS = 6'd5;
`ifdef FPU_SLOT_DIVSQRT_EN
   localparam bit DIVEN = 1'b1;
`else
   localparam bit DIVEN = 1'b0;
`endif

   typedef struct {
      int          acc;
      logic [IW-1:0] id;
      logic        err;
   } pipe_t;

   logic          clk;
   logic          rst_n;
   logic          req_i;
   logic [OW-1:0] op_i;
   logic [DW-1:0] operand_a_i, operand_b_i;
   logic [IW-1:0] id_i;
   logic          gnt_o;
   logic          rvalid_o;
   logic [DW-1:0] rdata_o;
   logic [4:0]    rflags_o;
   logic [IW-1:0] rid_o;
   logic          ex_valid_o;
   logic [OW-1:0] ex_op_o;
   logic [DW-1:0] ex_a_o, ex_b_o;
   logic [DW-1:0] ex_res_i;
   logic [4:0]    ex_flags_i;
   logic          div_start_o;
   logic          div_done_i;
   logic [DW-1:0] div_res_i;
   logic [4:0]    div_flags_i;
   logic          busy_o;

   int checks = 0;
   int errors = 0;

   fpu_slot_responder #(
      .DATA_WIDTH (DW),
      .OP_WIDTH   (OW),
      .ID_WIDTH   (IW),
      .LATENCY    (L),
      .OP_DIV     (4),
      .OP_SQRT    (5)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_i       (req_i),
      .op_i        (op_i),
      .operand_a_i (operand_a_i),
      .operand_b_i (operand_b_i),
      .id_i        (id_i),
      .gnt_o       (gnt_o),
      .rvalid_o    (rvalid_o),
      .rdata_o     (rdata_o),
      .rflags_o    (rflags_o),
      .rid_o       (rid_o),
      .ex_valid_o  (ex_valid_o),
      .ex_op_o     (ex_op_o),
      .ex_a_o      (ex_a_o),
      .ex_b_o      (ex_b_o),
      .ex_res_i    (ex_res_i),
      .ex_flags_i  (ex_flags_i),
      .div_start_o (div_start_o),
      .div_done_i  (div_done_i),
      .div_res_i   (div_res_i),
      .div_flags_i (div_flags_i),
      .busy_o      (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic idle_inputs();
      req_i       = 1'b0;
      op_i        = '0;
      operand_a_i = '0;
      operand_b_i = '0;
      id_i        = '0;
      ex_res_i    = '0;
      ex_flags_i  = '0;
      div_done_i  = 1'b0;
      div_res_i   = '0;
      div_flags_i = '0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      idle_inputs();
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   // -------------------------------------------------------------------------
   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL reset rvalid: got %b want 0", rvalid_o); end
      checks++; if (rdata_o !== '0) begin errors++; $display("FAIL reset rdata: got %h want 0", rdata_o); end
      checks++; if (rflags_o !== 5'b0) begin errors++; $display("FAIL reset rflags: got %b want 0", rflags_o); end
      checks++; if (rid_o !== '0) begin errors++; $display("FAIL reset rid: got %h want 0", rid_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy_o); end
      checks++; if (gnt_o !== 1'b0) begin errors++; $display("FAIL reset gnt idle: got %b want 0", gnt_o); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      req_i = 1'b1;
      op_i  = 6'd1;
      #3;
      checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL reset gnt pipe: got %b want 1", gnt_o); end
      checks++; if (ex_valid_o !== 1'b1) begin errors++; $display("FAIL reset ex_valid: got %b want 1", ex_valid_o); end
      checks++; if (div_start_o !== 1'b0) begin errors++; $display("FAIL reset div_start pipe: got %b want 0", div_start_o); end
      op_i = OPD;
      #1;
      checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL reset gnt div: got %b want 1", gnt_o); end
      checks++; if (div_start_o !== DIVEN) begin errors++; $display("FAIL reset div_start div: got %b want %b", div_start_o, DIVEN); end
      checks++; if (ex_valid_o !== 1'b0) begin errors++; $display("FAIL reset ex_valid div: got %b want 0", ex_valid_o); end
      req_i = 1'b0;
      #1;
      checks++; if (gnt_o !== 1'b0) begin errors++; $display("FAIL reset gnt drop: got %b want 0", gnt_o); end
   endtask

   // -------------------------------------------------------------------------
   // Ids 1,2,3 issued back to back; responses at c+L carrying ex_res of c+L-1.
   task automatic test_pipe_order();
      logic [DW-1:0] res [16];
      logic [4:0]    fl  [16];
      logic          erv;
      do_reset();
      for (int c = 0; c < L + 5; c++) begin
         @(posedge clk); #1;
         req_i       = (c < 3);
         op_i        = OW'(c + 1);
         id_i        = IW'(c + 1);
         operand_a_i = $urandom;
         operand_b_i = $urandom;
         res[c]      = $urandom;
         fl[c]       = 5'($urandom);
         ex_res_i    = res[c];
         ex_flags_i  = fl[c];
         #3;
         if (c < 3) begin
            checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL b2b gnt c%0d: got %b want 1", c, gnt_o); end
            checks++; if (ex_valid_o !== 1'b1) begin errors++; $display("FAIL b2b ex_valid c%0d: got %b want 1", c, ex_valid_o); end
            checks++; if (ex_a_o !== operand_a_i) begin errors++; $display("FAIL b2b ex_a c%0d: got %h want %h", c, ex_a_o, operand_a_i); end
         end
         erv = (c >= L) && (c < L + 3);
         checks++; if (rvalid_o !== erv) begin errors++; $display("FAIL b2b rvalid c%0d: got %b want %b", c, rvalid_o, erv); end
         if (erv) begin
            checks++; if (rid_o !== IW'(c - L + 1)) begin errors++; $display("FAIL b2b rid c%0d: got %0d want %0d", c, rid_o, c - L + 1); end
            checks++; if (rdata_o !== res[c-1]) begin errors++; $display("FAIL b2b rdata c%0d: got %h want %h", c, rdata_o, res[c-1]); end
            checks++; if (rflags_o !== fl[c-1]) begin errors++; $display("FAIL b2b rflags c%0d: got %b want %b", c, rflags_o, fl[c-1]); end
         end
      end
      idle_inputs();
   endtask

`ifdef FPU_SLOT_DIVSQRT_EN
   // -------------------------------------------------------------------------
   // Div waits for pipe drain, blocks grants while busy, then min-latency div.
   task automatic test_div_path();
      logic [DW-1:0] res [24];
      logic [4:0]    fl  [24];
      logic [DW-1:0] r2;
      logic          eg, ex, eds, erv, eb;
      logic [IW-1:0] erid;
      logic [DW-1:0] erd;
      logic [4:0]    erf;
      r2 = $urandom;
      do_reset();
      for (int c = 0; c <= 20; c++) begin
         @(posedge clk); #1;
         idle_inputs();
         res[c] = $urandom;
         fl[c]  = 5'($urandom);
         ex_res_i   = res[c];
         ex_flags_i = fl[c];
         {eg, ex, eds, erv, eb} = '0;
         erid = '0; erd = '0; erf = '0;
         case (c)
            0: begin req_i = 1; op_i = 6'd1; id_i = 6'd20; eg = 1; ex = 1; end
            1, 2: begin req_i = 1; op_i = OPD; id_i = 6'd9; eb = 1; end
            3: begin
               req_i = 1; op_i = OPD; id_i = 6'd9; eg = 1; eds = 1; eb = 1;
               erv = 1; erid = 6'd20; erd = res[2]; erf = fl[2];
            end
            4, 5, 6, 7, 8, 9: begin req_i = 1; op_i = 6'd2; id_i = 6'd30; eb = 1; end
            10: begin
               req_i = 1; op_i = 6'd2; id_i = 6'd30; eb = 1;
               div_done_i = 1; div_res_i = 32'h3F80_0000; div_flags_i = 5'b0;
            end
            11: begin
               req_i = 1; op_i = 6'd2; id_i = 6'd30; eg = 1; ex = 1; eb = 1;
               erv = 1; erid = 6'd9; erd = 32'h3F80_0000; erf = 5'b0;
            end
            12, 13: eb = 1;
            14: begin eb = 1; erv = 1; erid = 6'd30; erd = res[13]; erf = fl[13]; end
            16: begin req_i = 1; op_i = OPS; id_i = 6'd11; eg = 1; eds = 1; end
            17: begin eb = 1; div_done_i = 1; div_res_i = r2; div_flags_i = 5'b00011; end
            18: begin eb = 1; erv = 1; erid = 6'd11; erd = r2; erf = 5'b00011; end
            19: begin div_done_i = 1; div_res_i = ~r2; end
            default: ;
         endcase
         #3;
         checks++; if (gnt_o !== eg) begin errors++; $display("FAIL div gnt c%0d: got %b want %b", c, gnt_o, eg); end
         checks++; if (ex_valid_o !== ex) begin errors++; $display("FAIL div ex_valid c%0d: got %b want %b", c, ex_valid_o, ex); end
         checks++; if (div_start_o !== eds) begin errors++; $display("FAIL div div_start c%0d: got %b want %b", c, div_start_o, eds); end
         checks++; if (rvalid_o !== erv) begin errors++; $display("FAIL div rvalid c%0d: got %b want %b", c, rvalid_o, erv); end
         checks++; if (busy_o !== eb) begin errors++; $display("FAIL div busy c%0d: got %b want %b", c, busy_o, eb); end
         if (erv) begin
            checks++; if (rid_o !== erid) begin errors++; $display("FAIL div rid c%0d: got %0d want %0d", c, rid_o, erid); end
            checks++; if (rdata_o !== erd) begin errors++; $display("FAIL div rdata c%0d: got %h want %h", c, rdata_o, erd); end
            checks++; if (rflags_o !== erf) begin errors++; $display("FAIL div rflags c%0d: got %b want %b", c, rflags_o, erf); end
         end
      end
      idle_inputs();
   endtask
`else
   // -------------------------------------------------------------------------
   // Div-class ops without the iterative unit: NV error responses in order.
   task automatic test_div_error();
      logic [DW-1:0] res [8];
      logic [4:0]    fl  [8];
      do_reset();
      for (int c = 0; c < 7; c++) begin
         @(posedge clk); #1;
         idle_inputs();
         res[c] = $urandom | 32'h1;
         fl[c]  = 5'($urandom);
         ex_res_i   = res[c];
         ex_flags_i = fl[c];
         div_done_i = (c == 3);
         div_res_i  = $urandom;
         if (c == 0) begin req_i = 1; op_i = OPD; id_i = 6'd7; end
         if (c == 1) begin req_i = 1; op_i = OPS; id_i = 6'd8; end
         if (c == 2) begin req_i = 1; op_i = 6'd3; id_i = 6'd12; end
         #3;
         if (c < 2) begin
            checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL nodiv gnt c%0d: got %b want 1", c, gnt_o); end
            checks++; if (ex_valid_o !== 1'b0) begin errors++; $display("FAIL nodiv ex_valid c%0d: got %b want 0", c, ex_valid_o); end
            checks++; if (div_start_o !== 1'b0) begin errors++; $display("FAIL nodiv div_start c%0d: got %b want 0", c, div_start_o); end
         end
         checks++; if (rvalid_o !== (c >= 3 && c <= 5)) begin errors++; $display("FAIL nodiv rvalid c%0d: got %b", c, rvalid_o); end
         if (c == 3 || c == 4) begin
            checks++; if (rid_o !== IW'(c + 4)) begin errors++; $display("FAIL nodiv rid c%0d: got %0d want %0d", c, rid_o, c + 4); end
            checks++; if (rdata_o !== '0) begin errors++; $display("FAIL nodiv rdata c%0d: got %h want 0", c, rdata_o); end
            checks++; if (rflags_o !== 5'b10000) begin errors++; $display("FAIL nodiv rflags c%0d: got %b want 10000", c, rflags_o); end
         end
         if (c == 5) begin
            checks++; if (rid_o !== 6'd12) begin errors++; $display("FAIL nodiv rid c5: got %0d want 12", rid_o); end
            checks++; if (rdata_o !== res[4]) begin errors++; $display("FAIL nodiv rdata c5: got %h want %h", rdata_o, res[4]); end
         end
         if (c == 6) begin
            checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL nodiv busy c6: got %b want 0", busy_o); end
         end
      end
      idle_inputs();
   endtask
`endif

   // -------------------------------------------------------------------------
   // Reset with work outstanding drops it; stray div_done_i is ignored.
   task automatic test_reset_mid();
      do_reset();
      @(posedge clk); #1;
      req_i = 1; op_i = 6'd1; id_i = 6'd1;
      @(posedge clk); #1;
      req_i = 0;
      rst_n = 0;
      #3;
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rstmid busy in reset: got %b want 0", busy_o); end
      for (int c = 0; c < L + 2; c++) begin
         @(posedge clk); #1;
         rst_n      = 1;
         div_done_i = 1;
         div_res_i  = $urandom;
         #3;
         checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL rstmid rvalid c%0d: got %b want 0", c, rvalid_o); end
         checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rstmid busy c%0d: got %b want 0", c, busy_o); end
         checks++; if (gnt_o !== req_i) begin errors++; $display("FAIL rstmid gnt c%0d: got %b want %b", c, gnt_o, req_i); end
      end
      div_done_i = 0;
`ifdef FPU_SLOT_DIVSQRT_EN
      @(posedge clk); #1;
      req_i = 1; op_i = OPD; id_i = 6'd5;
      #3;
      checks++; if (div_start_o !== 1'b1) begin errors++; $display("FAIL rstmid div_start: got %b want 1", div_start_o); end
      @(posedge clk); #1;
      req_i = 0;
      #3;
      checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL rstmid div busy: got %b want 1", busy_o); end
      @(posedge clk); #1;
      rst_n = 0;
      #3;
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rstmid div busy in reset: got %b want 0", busy_o); end
      @(posedge clk); #1;
      rst_n = 1;
      div_done_i = 1;
      #3;
      checks++; if (gnt_o !== 1'b0) begin errors++; $display("FAIL rstmid gnt after: got %b want 0", gnt_o); end
      @(posedge clk); #1;
      div_done_i = 0;
      req_i = 1; op_i = 6'd1; id_i = 6'd2;
      #3;
      checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL rstmid stray done rvalid: got %b want 0", rvalid_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rstmid stray done busy: got %b want 0", busy_o); end
      checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL rstmid gnt req: got %b want 1", gnt_o); end
`endif
      idle_inputs();
   endtask

   // -------------------------------------------------------------------------
   // Random traffic against a transaction-level model: each accepted op is a
   // record with an accept cycle; a pipe response is due at accept+L, a div
   // response the cycle after its first honoured done strobe.
   task automatic test_random();
      logic [DW-1:0] hres [NC];
      logic [4:0]    hfl  [NC];
      pipe_t         pq [$];
      pipe_t         ent;
      logic          pend, div_busy, dresp_v, have_last, isd, recent;
      logic          e_gnt, e_exv, e_ds, e_rv, e_busy, e_pipe;
      int            dresp_c;
      logic [IW-1:0] div_id, dresp_id, e_rid, last_id;
      logic [DW-1:0] dresp_data, e_rdata, last_data;
      logic [4:0]    dresp_fl, e_rfl, last_fl;
      do_reset();
      pend = 0; div_busy = 0; dresp_v = 0; have_last = 0; dresp_c = 0;
      div_id = '0; dresp_id = '0; dresp_data = '0; dresp_fl = '0;
      last_id = '0; last_data = '0; last_fl = '0;
      for (int c = 0; c < NC; c++) begin
         @(posedge clk); #1;
         if (!pend && ($urandom_range(3) != 0)) begin
            pend = 1;
            if ($urandom_range(3) == 0) begin
               op_i = ($urandom_range(1) == 0) ? OPD : OPS;
            end else begin
               op_i = OW'($urandom_range(63));
               if (op_i == OPD || op_i == OPS) op_i = '0;
            end
            id_i        = IW'($urandom);
            operand_a_i = $urandom;
            operand_b_i = $urandom;
         end
         req_i       = pend;
         hres[c]     = $urandom;
         hfl[c]      = 5'($urandom);
         ex_res_i    = hres[c];
         ex_flags_i  = hfl[c];
         div_done_i  = div_busy ? ($urandom_range(2) == 0) : ($urandom_range(7) == 0);
         div_res_i   = $urandom;
         div_flags_i = 5'($urandom);
         #3;
         isd    = (op_i == OPD) || (op_i == OPS);
         recent = 0;
         foreach (pq[k]) if (pq[k].acc + L > c) recent = 1;
         e_gnt  = pend && !div_busy && !(DIVEN && isd && recent);
         e_exv  = e_gnt && !isd;
         e_ds   = DIVEN && e_gnt && isd;
         e_rv = 0; e_pipe = 0; e_rid = '0; e_rdata = '0; e_rfl = '0;
         if (pq.size() > 0 && pq[0].acc + L == c) begin
            e_rv = 1; e_pipe = 1; e_rid = pq[0].id;
            e_rdata = pq[0].err ? '0 : hres[c-1];
            e_rfl   = pq[0].err ? 5'b10000 : hfl[c-1];
         end else if (dresp_v && dresp_c == c) begin
            e_rv = 1; e_rid = dresp_id; e_rdata = dresp_data; e_rfl = dresp_fl;
         end
         e_busy = div_busy || (pq.size() > 0) || (dresp_v && dresp_c == c);

         checks++; if (gnt_o !== e_gnt) begin errors++; $display("FAIL rand gnt c%0d: got %b want %b", c, gnt_o, e_gnt); end
         checks++; if (ex_valid_o !== e_exv) begin errors++; $display("FAIL rand ex_valid c%0d: got %b want %b", c, ex_valid_o, e_exv); end
         checks++; if (div_start_o !== e_ds) begin errors++; $display("FAIL rand div_start c%0d: got %b want %b", c, div_start_o, e_ds); end
         checks++; if (rvalid_o !== e_rv) begin errors++; $display("FAIL rand rvalid c%0d: got %b want %b", c, rvalid_o, e_rv); end
         checks++; if (busy_o !== e_busy) begin errors++; $display("FAIL rand busy c%0d: got %b want %b", c, busy_o, e_busy); end
         if (e_rv || have_last) begin
            if (!e_rv) begin e_rid = last_id; e_rdata = last_data; e_rfl = last_fl; end
            checks++; if (rid_o !== e_rid) begin errors++; $display("FAIL rand rid c%0d: got %0d want %0d", c, rid_o, e_rid); end
            checks++; if (rdata_o !== e_rdata) begin errors++; $display("FAIL rand rdata c%0d: got %h want %h", c, rdata_o, e_rdata); end
            checks++; if (rflags_o !== e_rfl) begin errors++; $display("FAIL rand rflags c%0d: got %b want %b", c, rflags_o, e_rfl); end
         end
         if (req_i) begin
            checks++; if (ex_op_o !== op_i) begin errors++; $display("FAIL rand ex_op c%0d: got %h want %h", c, ex_op_o, op_i); end
         end

         if (e_rv) begin
            have_last = 1; last_id = e_rid; last_data = e_rdata; last_fl = e_rfl;
            if (e_pipe) void'(pq.pop_front());
            else dresp_v = 0;
         end
         if (div_busy && div_done_i) begin
            dresp_v = 1; dresp_c = c + 1; dresp_id = div_id;
            dresp_data = div_res_i; dresp_fl = div_flags_i;
            div_busy = 0;
         end
         if (e_gnt) begin
            pend = 0;
            if (DIVEN && isd) begin
               div_busy = 1;
               div_id   = id_i;
            end else begin
               ent.acc = c; ent.id = id_i; ent.err = isd;
               pq.push_back(ent);
            end
         end
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_pipe_order();
`ifdef FPU_SLOT_DIVSQRT_EN
      test_div_path();
`else
      test_div_error();
`endif
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fpu_slot_responder.md
# fpu_slot_responder

FPU-side responder for one shared FPU slot on the cluster FPU interconnect: it accepts req/gnt operations, dispatches them to a fixed-latency pipelined datapath or an iterative div/sqrt unit, and returns in-order rvalid responses with result, flags and ID. Each accepted request (req_i & gnt_o) produces exactly one rvalid_o pulse. The block never returns two responses in one cycle. That guarantees the pending count held by the interconnect-side clock-gating logic is exact. busy_o is the slot-local activity indication.

## Interface
- DATA_WIDTH, 32, operand/result width
- OP_WIDTH, 6, opcode width
- ID_WIDTH, 6, response tag width
- LATENCY, 3, pipelined-datapath latency in cycles, 1..7
- OP_DIV, 4, opcode routed to the iterative unit
- OP_SQRT, 5, opcode routed to the iterative unit

Ports:
- clk  in  1  clock; one clock domain
- rst_n  in  1  asynchronous active-low reset
- req_i  in  1  request; held stable with its payload until granted
- op_i  in  OP_WIDTH  opcode
- operand_a_i, operand_b_i  in  DATA_WIDTH  operands
- id_i  in  ID_WIDTH  request tag
- gnt_o  out  1  grant, combinational
- rvalid_o  out  1  response valid, one-cycle pulse, no backpressure
- rdata_o  out  DATA_WIDTH  result
- rflags_o  out  5  IEEE flags {NV,DZ,OF,UF,NX}
- rid_o  out  ID_WIDTH  tag of the response
- ex_valid_o  out  1  issue to pipelined datapath
- ex_op_o, ex_a_o, ex_b_o  out  OP_WIDTH/DATA_WIDTH  pass-through of op_i/operands
- ex_res_i, ex_flags_i  in  DATA_WIDTH/5  pipelined result; valid LATENCY-1 cycles after issue
- div_start_o  out  1  start pulse to the iterative unit
- div_done_i, div_res_i, div_flags_i  in  1/DATA_WIDTH/5  iterative completion strobe and result
- busy_o  out  1  slot has work outstanding

## Operation
- FSM states: IDLE, DIV_BUSY.
- Class: "div" when op_i is OP_DIV or OP_SQRT; otherwise "pipe".
- gnt_o for pipe: req_i & (state==IDLE).
- gnt_o for div: req_i & (state==IDLE) & inflight empty.
- ex_valid_o = req_i & gnt_o & pipe. div_start_o = req_i & gnt_o & div.
- Inflight tracking uses a LATENCY-stage shift register of {valid, id}. Stage LATENCY-1 valid captures ex_res_i/ex_flags_i/id into the response registers. rvalid_o asserts the next cycle.
- Div accept: latch id_i and go to DIV_BUSY.
- In DIV_BUSY: gnt_o=0. div_done_i captures div_res_i/div_flags_i/latched id. rvalid_o asserts the next cycle and the FSM returns to IDLE.
- div_done_i outside DIV_BUSY is ignored.
- Responses are strictly in issue order; ordering is guaranteed by the div-waits-for-empty rule.
- busy_o = (state!=IDLE) | any inflight valid | rvalid_o.
- rdata_o/rflags_o/rid_o hold their last value when rvalid_o=0.

## Timing
- Reset values: rvalid_o=0, rdata_o=0, rflags_o=0, rid_o=0, busy_o=0, state IDLE, inflight cleared.
- After reset, gnt_o/ex_valid_o/div_start_o follow req_i combinationally.
- Pipe accepted in cycle t: rvalid_o in cycle t+LATENCY. Throughput is one per cycle.
- Div accepted in cycle t: rvalid_o one cycle after the div_done_i cycle. Minimum latency is 2.
- In the cycle the FSM returns to IDLE (rvalid_o high), gnt_o may assert again.
- Reset mid-operation drops all outstanding ops. No rvalid is generated for them, and a later div_done_i is ignored.

## Configuration
- FPU_SLOT_DIVSQRT_EN defined: iterative path present as above.
- FPU_SLOT_DIVSQRT_EN undefined:
  - No DIV_BUSY state; div_start_o tied 0; div_* inputs ignored.
  - Div-class ops use the pipe grant rule with ex_valid_o=0. They travel the delay line with an error bit.
  - Their response comes at t+LATENCY with rdata_o=0 and rflags_o=5'b10000, independent of ex_res_i.

## Test plan
- LATENCY=3, pipe ids 1,2,3 accepted in cycles 0,1,2 -> rvalid_o in cycles 3,4,5 with rid 1,2,3 and rdata equal to ex_res_i from cycles 2,3,4.
- Pipe accepted in cycle 0, div req from cycle 1 -> gnt_o=0 in cycles 1-2; gnt_o=1 and div_start_o=1 in cycle 3.
- Div accepted in cycle 3 with id 9; div_done_i in cycle 10 with res 0x3F800000, flags 0 -> gnt_o=0 in cycles 4-10; rvalid_o in cycle 11 with rid 9, rdata 0x3F800000; busy_o=0 in cycle 12.
- Pipe req held during the div_done_i cycle -> gnt_o=0 that cycle, gnt_o=1 the next cycle.
- rst_n low during DIV_BUSY, div_done_i pulsed after release -> no rvalid_o, busy_o=0, gnt_o=req_i.
- Macro undefined, div op id 7 in cycle 0 -> gnt_o=1 in cycle 0 with div_start_o=0 and ex_valid_o=0; rvalid_o in cycle 3 with rid 7, rdata 0, rflags 5'b10000.
